// File: rtl/pipe_stat_ctrl_if.sv
// Status/command bundle between the pipeline stages and the stall/bubble controller.
// master = controller side, slave = datapath side.
interface pipe_stat_ctrl_if #(
    parameter int NSTAGE = 5,
    parameter int CNT_W  = 32
);
    localparam int SW = $clog2(NSTAGE);

    logic [NSTAGE-1:0]   busy;
    logic [NSTAGE-1:0]   flush_req;
    logic [NSTAGE-1:0]   hazard;
    logic                serialize_in;
    logic                cnt_clr;
    logic [2*NSTAGE-1:0] stat;
    logic                redirect;
    logic [SW-1:0]       redirect_src;
    logic                redirect_pending;
    logic                ser_active;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    modport master (
        input  busy, flush_req, hazard, serialize_in, cnt_clr,
        output stat, redirect, redirect_src, redirect_pending, ser_active,
               stall_cnt, flush_cnt
    );

    modport slave (
        output busy, flush_req, hazard, serialize_in, cnt_clr,
        input  stat, redirect, redirect_src, redirect_pending, ser_active,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stat_ctrl.sv
// Per-stage NORMAL/STALL/BUBBLE controller with deferred redirect, serialising
// drain and saturating stall/flush counters.
module pipe_stat_ctrl #(
    parameter int NSTAGE    = 5,
    parameter int SER_DRAIN = 3,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             resetn,
    pipe_stat_ctrl_if.master bus
);
    localparam int SW = $clog2(NSTAGE);
    localparam logic [1:0] CMD_NORMAL = 2'b00;
    localparam logic [1:0] CMD_STALL  = 2'b01;
    localparam logic [1:0] CMD_BUBBLE = 2'b10;

    typedef enum logic {IDLE, WAIT_FETCH} state_t;

    state_t              state_q, state_d;
    logic [3:0]          ser_q, ser_d;
    logic [SW-1:0]       src_q, src_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0]    flush_q, flush_d;
    logic [2*NSTAGE-1:0] stat;
    logic                redirect;
    logic                accept;

    logic                b_vld, f_vld, h_vld;
    logic [SW-1:0]       b_idx, f_idx, h_idx;
    logic                unused_hazard_ends;

    assign unused_hazard_ends = bus.hazard[0] ^ bus.hazard[NSTAGE-1];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Ascending scans so the oldest (highest-index) requester wins.
    always_comb begin
        b_vld = 1'b0; b_idx = '0;
        f_vld = 1'b0; f_idx = '0;
        h_vld = 1'b0; h_idx = '0;
        for (int k = 1; k < NSTAGE; k++)
            if (bus.busy[k]) begin b_vld = 1'b1; b_idx = SW'(k); end
        for (int k = 0; k < NSTAGE; k++)
            if (bus.flush_req[k]) begin f_vld = 1'b1; f_idx = SW'(k); end
        for (int k = 1; k < NSTAGE - 1; k++)
            if (bus.hazard[k]) begin h_vld = 1'b1; h_idx = SW'(k); end
    end

    always_comb begin
        stat     = '0;
        redirect = 1'b0;
        accept   = 1'b0;
        state_d  = state_q;
        ser_d    = ser_q;
        src_d    = src_q;
        if (!resetn) begin
            stat = '0;
        end else if (b_vld) begin
            for (int k = 0; k < NSTAGE; k++)
                if (k <= int'(b_idx))          stat[2*k +: 2] = CMD_STALL;
                else if (k == int'(b_idx) + 1) stat[2*k +: 2] = CMD_BUBBLE;
        end else if (state_q == WAIT_FETCH) begin
            for (int k = 1; k < NSTAGE; k++) stat[2*k +: 2] = CMD_BUBBLE;
            if (bus.busy[0]) begin
                stat[1:0] = CMD_STALL;
            end else begin
                redirect = 1'b1;
                state_d  = IDLE;
                ser_d    = '0;
            end
        end else if (f_vld) begin
            accept = 1'b1;
            src_d  = f_idx;
            ser_d  = '0;
            for (int k = 1; k < NSTAGE; k++)
                if (k <= int'(f_idx)) stat[2*k +: 2] = CMD_BUBBLE;
            if (bus.busy[0]) begin
                stat[1:0] = CMD_STALL;
                state_d   = WAIT_FETCH;
            end else begin
                redirect = 1'b1;
            end
        end else if (h_vld) begin
            for (int k = 0; k < NSTAGE; k++)
                if (k <= int'(h_idx))          stat[2*k +: 2] = CMD_STALL;
                else if (k == int'(h_idx) + 1) stat[2*k +: 2] = CMD_BUBBLE;
        end else if (bus.busy[0]) begin
            stat[1:0] = CMD_STALL;
            stat[3:2] = CMD_BUBBLE;
        end else if (ser_q != 4'd0 || bus.serialize_in) begin
            stat[1:0] = CMD_STALL;
            stat[3:2] = CMD_BUBBLE;
            // Reaching here with an empty counter implies serialize_in is set.
            if (ser_q == 4'd0) ser_d = 4'(SER_DRAIN);
            else               ser_d = ser_q - 4'd1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (bus.cnt_clr) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (stat[1:0] != CMD_NORMAL) stall_d = sat_inc(stall_q);
            if (accept)                  flush_d = sat_inc(flush_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            ser_q   <= '0;
            src_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            ser_q   <= ser_d;
            src_q   <= src_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.stat             = stat;
    assign bus.redirect         = redirect;
    assign bus.redirect_src     = src_q;
    assign bus.redirect_pending = (state_q == WAIT_FETCH);
    assign bus.ser_active       = (ser_q != 4'd0);
    assign bus.stall_cnt        = stall_q;
    assign bus.flush_cnt        = flush_q;
endmodule

// File: tb/tb_pipe_stat_ctrl.sv
// Scoreboard bench for pipe_stat_ctrl: directed steps push expected outputs,
// a negedge monitor pops and compares. A CNT_W=4 twin checks saturation.
module tb_pipe_stat_ctrl;
    localparam logic [1:0] CN = 2'b00;
    localparam logic [1:0] CS = 2'b01;
    localparam logic [1:0] CB = 2'b10;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] busy, flush, haz;
    logic       ser_in, clr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic [9:0] stat;
        logic       red;
        logic [2:0] src;
        logic       pend;
        logic       ser;
        int         sc;
        int         fc;
        int         sc4;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_stat_ctrl_if #(.NSTAGE(5), .CNT_W(32)) if1 ();
    pipe_stat_ctrl_if #(.NSTAGE(5), .CNT_W(4))  if2 ();

    assign if1.busy = busy;   assign if2.busy = busy;
    assign if1.flush_req = flush; assign if2.flush_req = flush;
    assign if1.hazard = haz;  assign if2.hazard = haz;
    assign if1.serialize_in = ser_in; assign if2.serialize_in = ser_in;
    assign if1.cnt_clr = clr; assign if2.cnt_clr = clr;

    pipe_stat_ctrl #(.NSTAGE(5), .SER_DRAIN(3), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .bus(if1)
    );
    pipe_stat_ctrl #(.NSTAGE(5), .SER_DRAIN(3), .CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .bus(if2)
    );

    function automatic logic [9:0] st(input logic [1:0] s4, s3, s2, s1, s0);
        return {s4, s3, s2, s1, s0};
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic rn, input logic [4:0] b, f, h,
                        input logic si, cl, input logic [9:0] es, input logic er,
                        input logic [2:0] esrc, input logic ep, eser,
                        input int esc, efc, esc4);
        exp_t e;
        resetn = rn; busy = b; flush = f; haz = h; ser_in = si; clr = cl;
        e.name = nm; e.stat = es; e.red = er; e.src = esrc; e.pend = ep;
        e.ser = eser; e.sc = esc; e.fc = efc; e.sc4 = esc4;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "stat",  32'(if1.stat),             32'(e.stat));
            chk(e.name, "redir", 32'(if1.redirect),         32'(e.red));
            chk(e.name, "src",   32'(if1.redirect_src),     32'(e.src));
            chk(e.name, "pend",  32'(if1.redirect_pending), 32'(e.pend));
            chk(e.name, "ser",   32'(if1.ser_active),       32'(e.ser));
            chk(e.name, "stall", if1.stall_cnt,             32'(e.sc));
            chk(e.name, "flush", if1.flush_cnt,             32'(e.fc));
            chk(e.name, "stall4", 32'(if2.stall_cnt),       32'(e.sc4));
        end
    end

    initial begin
        resetn = 1'b0; busy = '0; flush = '0; haz = '0; ser_in = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        //         name        rn  busy      flush     haz       si cl stat                    red src pend ser sc  fc sc4
        step("rst_busy",   0, 5'b01000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CN,CN), 0, 0, 0, 0, 0,  0, 0);
        step("mem_busy1",  1, 5'b01000, 5'b00000, 5'b00000, 0, 0, st(CB,CS,CS,CS,CS), 0, 0, 0, 0, 0,  0, 0);
        step("mem_busy2",  1, 5'b01000, 5'b00000, 5'b00000, 0, 0, st(CB,CS,CS,CS,CS), 0, 0, 0, 0, 1,  0, 1);
        step("mem_done",   1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CN,CN), 0, 0, 0, 0, 2,  0, 2);
        step("flush4",     1, 5'b00000, 5'b10000, 5'b00000, 0, 0, st(CB,CB,CB,CB,CN), 1, 0, 0, 0, 2,  0, 2);
        step("flush4_aft", 1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CN,CN), 0, 4, 0, 0, 2,  1, 2);
        step("fbusy_c0",   1, 5'b00001, 5'b01000, 5'b00000, 0, 0, st(CN,CB,CB,CB,CS), 0, 4, 0, 0, 2,  1, 2);
        step("fbusy_c1",   1, 5'b00001, 5'b01000, 5'b00000, 0, 0, st(CB,CB,CB,CB,CS), 0, 3, 1, 0, 3,  2, 3);
        step("fbusy_c2",   1, 5'b00001, 5'b00000, 5'b00000, 0, 0, st(CB,CB,CB,CB,CS), 0, 3, 1, 0, 4,  2, 4);
        step("fbusy_c3",   1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CB,CB,CB,CB,CN), 1, 3, 1, 0, 5,  2, 5);
        step("fbusy_idle", 1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CN,CN), 0, 3, 0, 0, 5,  2, 5);
        step("load_use",   1, 5'b00000, 5'b00000, 5'b00100, 0, 0, st(CN,CB,CS,CS,CS), 0, 3, 0, 0, 5,  2, 5);
        step("haz_ends",   1, 5'b00000, 5'b00000, 5'b10001, 0, 0, st(CN,CN,CN,CN,CN), 0, 3, 0, 0, 6,  2, 6);
        step("ser_pulse",  1, 5'b00000, 5'b00000, 5'b00000, 1, 0, st(CN,CN,CN,CB,CS), 0, 3, 0, 0, 6,  2, 6);
        step("ser_d1",     1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CB,CS), 0, 3, 0, 1, 7,  2, 7);
        step("ser_d2",     1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CB,CS), 0, 3, 0, 1, 8,  2, 8);
        step("ser_d3",     1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CB,CS), 0, 3, 0, 1, 9,  2, 9);
        step("ser_end",    1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CN,CN), 0, 3, 0, 0, 10, 2, 10);
        step("ser_pulse2", 1, 5'b00000, 5'b00000, 5'b00000, 1, 0, st(CN,CN,CN,CB,CS), 0, 3, 0, 0, 10, 2, 10);
        step("ser_flush",  1, 5'b00000, 5'b00100, 5'b00000, 0, 0, st(CN,CN,CB,CB,CN), 1, 3, 0, 1, 11, 2, 11);
        step("ser_killed", 1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CN,CN), 0, 2, 0, 0, 11, 3, 11);
        for (int i = 0; i < 6; i++)
            step($sformatf("fetch_busy%0d", i), 1, 5'b00001, 5'b00000, 5'b00000, 0, 0,
                 st(CN,CN,CN,CB,CS), 0, 2, 0, 0, 11 + i, 3, (11 + i > 15) ? 15 : 11 + i);
        step("sat_check",  1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CN,CN), 0, 2, 0, 0, 17, 3, 15);
        step("wait_enter", 1, 5'b00001, 5'b00010, 5'b00000, 0, 0, st(CN,CN,CN,CB,CS), 0, 2, 0, 0, 17, 3, 15);
        step("wait_rst",   0, 5'b00001, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CN,CN), 0, 1, 1, 0, 18, 4, 15);
        step("after_rst",  1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CN,CN), 0, 0, 0, 0, 0,  0, 0);
        step("clr_pre",    1, 5'b01000, 5'b00000, 5'b00000, 0, 0, st(CB,CS,CS,CS,CS), 0, 0, 0, 0, 0,  0, 0);
        step("clr_wins",   1, 5'b01000, 5'b00000, 5'b00000, 0, 1, st(CB,CS,CS,CS,CS), 0, 0, 0, 0, 1,  0, 1);
        step("clr_aft",    1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CN,CN), 0, 0, 0, 0, 0,  0, 0);
        step("busy_frz",   1, 5'b00100, 5'b10000, 5'b00000, 0, 0, st(CN,CB,CS,CS,CS), 0, 0, 0, 0, 0,  0, 0);
        step("frz_accept", 1, 5'b00000, 5'b10000, 5'b00000, 0, 0, st(CB,CB,CB,CB,CN), 1, 0, 0, 0, 1,  0, 1);
        step("frz_aft",    1, 5'b00000, 5'b00000, 5'b00000, 0, 0, st(CN,CN,CN,CN,CN), 0, 4, 0, 0, 1,  1, 1);
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
